// File: rtl/encoder_4to2_serial.sv
// -----------------------------------------------------------------------------
// Module: encoder_4to2_serial
//
// Purpose
//   Serialising priority encoder.  The block accepts a multi-hot request word
//   and emits the binary index of each set bit as a separate token, one token
//   per output handshake, highest priority first.  It is the counterpart of a
//   2-to-4 one-hot decoder.  Valid/ready flow control is used on both sides.
//
// Configuration macro
//   ENC_LSB_FIRST_EN
//     undefined (default) : MSB-first order, the highest set bit leaves first
//     defined             : LSB-first order, the lowest set bit leaves first
//   The macro changes only the token order.  Ports, timing and handshake
//   behaviour are the same in both builds.
//
// Parameters
//   IN_W   width of the request vector (power of two, >= 2)
//   OUT_W  index width, must equal $clog2(IN_W)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   enable     in   1      global enable; low freezes the block and masks
//                          both handshakes
//   in_valid   in   1      request word valid
//   in_ready   out  1      block can accept a request word
//   in         in   IN_W   request vector; more than one bit may be set
//   out_valid  out  1      index token valid
//   out_ready  in   1      consumer accepts the token
//   out        out  OUT_W  index of the highest-priority pending bit
//   out_last   out  1      token is the last one for the current word
// -----------------------------------------------------------------------------
module encoder_4to2_serial #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_last
);

    // Stop elaboration when the parameters cannot describe a valid encoder.
    // A silent mismatch would truncate indices or leave index codes unused.
    if (OUT_W != $clog2(IN_W)) begin : g_bad_out_w
        $error("encoder_4to2_serial: OUT_W (%0d) must equal $clog2(IN_W) (%0d)",
               OUT_W, $clog2(IN_W));
    end

    if ((IN_W < 2) || ((IN_W & (IN_W - 1)) != 0)) begin : g_bad_in_w
        $error("encoder_4to2_serial: IN_W (%0d) must be a power of two >= 2",
               IN_W);
    end

    // IDLE waits for a request word.  EMIT drains the pending bits one
    // token at a time.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IN_W-1:0] pend;
    logic [IN_W-1:0] pend_nxt;

    logic [OUT_W-1:0] cur_idx;
    logic             cur_last;

    // Returns the index of the pending bit that leaves next.  The scan
    // runs so that the winning bit is the last one assigned.  With
    // MSB-first order the upward scan ends on the highest set bit.  With
    // LSB-first order the downward scan ends on the lowest set bit.
    function automatic logic [OUT_W-1:0] pick_index(input logic [IN_W-1:0] vec);
        logic [OUT_W-1:0] idx;
        idx = '0;
`ifdef ENC_LSB_FIRST_EN
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = OUT_W'(i);
            end
        end
`else
        for (int i = 0; i < IN_W; i++) begin
            if (vec[i]) begin
                idx = OUT_W'(i);
            end
        end
`endif
        return idx;
    endfunction

    // True when exactly one bit is set.  Clearing the lowest set bit of a
    // one-hot vector leaves zero.  The zero check excludes the empty vector.
    function automatic logic is_single_bit(input logic [IN_W-1:0] vec);
        return (vec != '0) && ((vec & (vec - IN_W'(1))) == '0);
    endfunction

    // The token fields depend only on the pending register.  They stay
    // stable while the consumer applies backpressure, because pend changes
    // only on a completed handshake.
    always_comb begin
        cur_idx  = pick_index(pend);
        cur_last = is_single_bit(pend);
    end

    // State register.  Reset discards any partially drained word.  When
    // enable is low, the next-state logic returns the current values, so
    // the registers hold and the interrupted token is presented again on
    // re-enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    // Next-state and output logic.  Every output is forced low while
    // enable is low, so neither handshake can complete.  in_ready is also
    // gated by rst, so no word is accepted while reset is held.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out       = '0;
        out_last  = 1'b0;

        case (state)
            IDLE: begin
                in_ready = enable & ~rst;
                // An all-zero word is consumed and dropped.  It has no
                // bits to report, so the block stays ready for the next
                // word.
                if (in_ready && in_valid && (in != '0)) begin
                    pend_nxt  = in;
                    state_nxt = EMIT;
                end
            end

            EMIT: begin
                if (enable) begin
                    out_valid = 1'b1;
                    out       = cur_idx;
                    out_last  = cur_last;
                    if (out_ready) begin
                        pend_nxt = pend & ~(IN_W'(1) << cur_idx);
                        if (cur_last) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                // Defensive recovery.  EMIT with nothing pending cannot be
                // reached through the handshakes, but if it occurs the
                // block returns to IDLE instead of stalling.
                if (pend == '0) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                pend_nxt  = '0;
            end
        endcase
    end

endmodule
